ext_intf_receiver: RTL and testbench
====================================

Name: ext_intf_receiver

Overview:
Far-end (slave-side) stage of the external host link; consumes the 16-bit transaction beat stream produced by the Core-B external sender. It reassembles header/address/write-data beats into one local bus request, runs it on a req/rdy master port, and returns the result as an 8-bit response beat stream. Link is synchronous to CLK; no CDC inside the block.

Parameters:
TIMEOUT_CYC, 1024, max cycles M_REQ may stay high without M_RDY before abort (>=2)
TO_W, 10, width of the timeout counter (must hold TIMEOUT_CYC-1)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
Ext_TRANS_VALID  in  1  transaction beat valid
Ext_TRANS_DATA  in  16  transaction beat payload
Ext_TRANS_ACK  out  1  beat accepted; a beat transfers when VALID&&ACK are both high in the same cycle
Ext_RESP_VALID  out  1  response beat valid
Ext_RESP_RESP  out  1  error flag, constant across all beats of one response
Ext_RESP_DATA  out  8  response payload
Ext_RESP_ACK  in  1  response beat accepted when VALID&&ACK
M_REQ  out  1  local request, held until M_RDY or timeout
M_WT  out  1  1=write 0=read
M_BE  out  4  byte enables
M_ADDR  out  32  address
M_WDT  out  32  write data
M_RDY  in  1  local transfer complete (1-cycle pulse, sampled only while M_REQ)
M_ERR  in  1  local error, valid with M_RDY
M_RDT  in  32  read data, valid with M_RDY
BUSY  out  1  high in any state other than HDR
TIMEOUT  out  1  one-cycle pulse on abort

Behaviour:
- Reset: state=HDR; Ext_TRANS_ACK=0, Ext_RESP_VALID=0, Ext_RESP_RESP=0, Ext_RESP_DATA=0, M_REQ=0, M_WT=0, M_BE=0, M_ADDR=0, M_WDT=0, BUSY=0, TIMEOUT=0. Reset mid-transaction drops everything; the partial transaction is lost.
- Beat order: header, ADDR[31:16], ADDR[15:0], then writes only WDT[31:16], WDT[15:0].
- Header: [15]=WT, [14:11]=BE, [10:0] reserved, ignored.
- Ext_TRANS_ACK is registered: high in HDR/AH/AL/DH/DL, low elsewhere. The first ACK is high the cycle after reset deasserts.
- FSM: HDR -> AH -> AL on each accepted beat. AL -> DH if WT, else ISSUE. DH -> DL -> ISSUE. With no VALID, the state holds.
- ISSUE: M_REQ=1 with registered fields. Entry occurs the cycle after the last beat is accepted; TO counter cleared. Stay while !M_RDY; counter increments each cycle.
- M_RDY while in ISSUE: M_REQ drops next cycle, M_RDT/M_ERR latched, go RESP.
- Counter reaches TIMEOUT_CYC-1 without M_RDY: M_REQ drops, TIMEOUT pulses 1 cycle, err=1, rdata=0, go RESP.
- M_RDY and timeout in the same cycle: M_RDY wins, TIMEOUT not pulsed.
- RESP read: 4 beats, M_RDT[31:24], [23:16], [15:8], [7:0]. RESP write: 1 beat, data 8'h00. Ext_RESP_RESP=err on every beat.
- Response stream: VALID stays high and data stays stable until ACK. Beat counter (2b) advances on VALID&&ACK. After the last beat, VALID drops next cycle and the FSM returns to HDR.
- Ext_TRANS_VALID during ISSUE/RESP is not acked (backpressure). The next transaction waits.

Decomposition:
- Shared package ext_intf_pkg: state encoding (HDR, AH, AL, DH, DL, ISSUE, RESP), header bit positions (HDR_WT=15, HDR_BE_HI=14, HDR_BE_LO=11), beat counts (REQ_BEATS_RD=3, REQ_BEATS_WR=5, RSP_BEATS_RD=4, RSP_BEATS_WR=1), WR_RESP_DATA=8'h00. Sender and receiver both use this package.
- One natural sub-module: ext_resp_serializer, which takes the 32b rdata + err + read/write flag, runs the VALID/ACK beat counter, and returns a done pulse.

Test Plan:
- Write, no stall: beats 16'h8800, 16'h1234, 16'h5678, 16'hDEAD, 16'hBEEF; M_RDY+!M_ERR 3 cycles after M_REQ -> M_WT=1, M_BE=4'h1, M_ADDR=32'h12345678, M_WDT=32'hDEADBEEF; single response beat data=8'h00, RESP=0.
- Read: beats 16'h7800, 16'h0000, 16'h0040; M_RDT=32'hCAFEF00D with M_RDY -> M_WT=0, M_BE=4'hF; response beats CA, FE, F0, 0D, RESP=0 on each.
- Response backpressure: same read, Ext_RESP_ACK low 5 cycles per beat -> data held stable while VALID, no beat skipped or duplicated, BUSY high until the last ACK.
- Timeout: TIMEOUT_CYC=8, read with M_RDY never asserted -> M_REQ high exactly 8 cycles, TIMEOUT pulse of 1 cycle, 4 beats of 8'h00 with RESP=1.
- Local error plus link backpressure: write with M_ERR=1 on M_RDY -> 1 beat with RESP=1. A new header driven during ISSUE sees ACK=0 and is accepted only after return to HDR.
- Reset mid-operation: RST pulsed after the AL beat -> all outputs reach reset values asynchronously, M_REQ never asserts, and the next full transaction completes normally.

Source files
------------

// File: rtl/ext_intf_pkg.sv
// ----------------------------------------------------------------------------
// ext_intf_pkg
// Items shared by both ends of the external host link (the Core-B sender and
// this receiver): FSM state encoding, header bit positions, beat counts and
// the fixed write-response payload.
// ----------------------------------------------------------------------------
package ext_intf_pkg;

   // Receiver FSM states. The link is only acknowledged in HDR..DL.
   typedef enum logic [2:0] {
      HDR   = 3'd0,
      AH    = 3'd1,
      AL    = 3'd2,
      DH    = 3'd3,
      DL    = 3'd4,
      ISSUE = 3'd5,
      RESP  = 3'd6
   } state_t;

   // Header beat layout: [15]=write, [14:11]=byte enables, [10:0] reserved.
   localparam int unsigned HDR_WT    = 15;
   localparam int unsigned HDR_BE_HI = 14;
   localparam int unsigned HDR_BE_LO = 11;

   // Request beats: header + 2 address beats, plus 2 data beats for writes.
   localparam int unsigned REQ_BEATS_RD = 3;
   localparam int unsigned REQ_BEATS_WR = 5;

   // Response beats: 4 read-data bytes MSB first, or one status-only beat.
   localparam int unsigned RSP_BEATS_RD = 4;
   localparam int unsigned RSP_BEATS_WR = 1;

   localparam logic [7:0] WR_RESP_DATA = 8'h00;

   // Number of request beats for a transaction type (used by the sender).
   function automatic int unsigned req_beats(input logic is_write);
      return is_write ? REQ_BEATS_WR : REQ_BEATS_RD;
   endfunction

   // Index of the final response beat, for a 2-bit beat counter.
   function automatic logic [1:0] rsp_last_beat(input logic is_read);
      return is_read ? 2'(RSP_BEATS_RD - 1) : 2'(RSP_BEATS_WR - 1);
   endfunction

endpackage

// File: rtl/ext_intf_receiver_if.sv
// ----------------------------------------------------------------------------
// Bus bundles used by ext_intf_receiver.
//
// ext_link_if  : external host link (16-bit request beats in, 8-bit response
//                beats out). master = sender side, slave = receiver side.
//   Ext_TRANS_VALID/DATA/ACK : request beat stream, transfer on VALID&&ACK
//   Ext_RESP_VALID/RESP/DATA/ACK : response beat stream, transfer on VALID&&ACK
//
// ext_mbus_if  : local req/rdy bus. master = receiver, slave = local target.
//   M_REQ/M_WT/M_BE/M_ADDR/M_WDT : request, held until M_RDY
//   M_RDY/M_ERR/M_RDT            : one-cycle completion with status/read data
// ----------------------------------------------------------------------------
interface ext_link_if;
   logic        Ext_TRANS_VALID;
   logic [15:0] Ext_TRANS_DATA;
   logic        Ext_TRANS_ACK;
   logic        Ext_RESP_VALID;
   logic        Ext_RESP_RESP;
   logic [7:0]  Ext_RESP_DATA;
   logic        Ext_RESP_ACK;

   modport master (
      output Ext_TRANS_VALID, Ext_TRANS_DATA, Ext_RESP_ACK,
      input  Ext_TRANS_ACK, Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_DATA
   );

   modport slave (
      input  Ext_TRANS_VALID, Ext_TRANS_DATA, Ext_RESP_ACK,
      output Ext_TRANS_ACK, Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_DATA
   );
endinterface

interface ext_mbus_if;
   logic        M_REQ;
   logic        M_WT;
   logic [3:0]  M_BE;
   logic [31:0] M_ADDR;
   logic [31:0] M_WDT;
   logic        M_RDY;
   logic        M_ERR;
   logic [31:0] M_RDT;

   modport master (
      output M_REQ, M_WT, M_BE, M_ADDR, M_WDT,
      input  M_RDY, M_ERR, M_RDT
   );

   modport slave (
      input  M_REQ, M_WT, M_BE, M_ADDR, M_WDT,
      output M_RDY, M_ERR, M_RDT
   );
endinterface

// File: rtl/ext_resp_serializer.sv
// ----------------------------------------------------------------------------
// ext_resp_serializer
// Turns one completed local transfer into the 8-bit response beat stream.
// Reads go out as 4 beats (rdata MSB first), writes as one WR_RESP_DATA beat.
// The error flag is repeated on every beat.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : one-cycle pulse; captures word/err/is_read and raises VALID
//   is_read     : 1 = 4-beat read response, 0 = 1-beat write response
//   word        : 32-bit read data (ignored for writes)
//   err         : error flag for the whole response
//   resp_ack    : link acknowledge, beat transfers on resp_valid && resp_ack
//   resp_valid  : beat valid, held with stable data until acknowledged
//   resp_err    : error flag of the current response
//   resp_data   : current beat payload
//   done        : one-cycle pulse in the cycle the last beat transfers
// ----------------------------------------------------------------------------
module ext_resp_serializer
   import ext_intf_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_read,
   input  logic [31:0] word,
   input  logic        err,
   input  logic        resp_ack,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [7:0]  resp_data,
   output logic        done
);

   logic [31:0] word_q;
   logic        err_q;
   logic        rd_q;
   logic [1:0]  cnt_q;
   logic        valid_q;
   logic        fire;
   logic        last;

   assign fire = valid_q && resp_ack;
   assign last = (cnt_q == rsp_last_beat(rd_q));
   assign done = fire && last;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (start) begin
         word_q  <= word;
         err_q   <= err;
         rd_q    <= is_read;
         cnt_q   <= '0;
         valid_q <= 1'b1;
      end else if (fire) begin
         if (last) begin
            valid_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 2'd1;
         end
      end
   end

   // Payload is a pure decode of held registers, so it cannot change while
   // VALID waits for ACK.
   // NOTE: every output of an always_comb gets a default first so no path
   // leaves it unassigned (which would infer a latch).
   always_comb begin
      resp_data = WR_RESP_DATA;
      if (rd_q) begin
         case (cnt_q)
            2'd0:    resp_data = word_q[31:24];
            2'd1:    resp_data = word_q[23:16];
            2'd2:    resp_data = word_q[15:8];
            default: resp_data = word_q[7:0];
         endcase
      end
   end

   assign resp_valid = valid_q;
   assign resp_err   = err_q;

endmodule

// File: rtl/ext_intf_receiver.sv
// ----------------------------------------------------------------------------
// ext_intf_receiver
// Far-end stage of the external host link. Collects header / address / write
// data beats into one local bus request, runs it on the req/rdy master port
// with a cycle-count abort, and returns status (and read data) as a response
// beat stream. Fully synchronous to CLK.
//
// Parameters:
//   TIMEOUT_CYC : max cycles M_REQ stays high without M_RDY (>= 2)
//   TO_W        : timeout counter width, must hold TIMEOUT_CYC-1
//
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   link     : ext_link_if.slave  - request beats in, response beats out
//   mbus     : ext_mbus_if.master - local bus request port
//   BUSY     : high whenever the FSM is not waiting for a header
//   TIMEOUT  : one-cycle pulse when a local request is aborted
// ----------------------------------------------------------------------------
module ext_intf_receiver
   import ext_intf_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned TO_W        = 10
) (
   input  logic        CLK,
   input  logic        RST,
   ext_link_if.slave   link,
   ext_mbus_if.master  mbus,
   output logic        BUSY,
   output logic        TIMEOUT
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t          state, next_state;
   logic            ack_q;
   logic            req_q;
   logic            timeout_q;
   logic            wt_q;
   logic [3:0]      be_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdt_q;
   logic [TO_W-1:0] to_cnt;

   logic            beat;
   logic            to_hit;
   logic            issue_done;
   logic            rsp_done;
   logic [31:0]     rsp_word;
   logic            rsp_err;

   assign beat       = link.Ext_TRANS_VALID && ack_q;
   assign to_hit     = (to_cnt == TO_LAST);
   assign issue_done = (state == ISSUE) && (mbus.M_RDY || to_hit);

   // A real completion beats a coincident timeout; an abort reports error
   // with zero read data.
   assign rsp_word = mbus.M_RDY ? mbus.M_RDT : 32'h0;
   assign rsp_err  = mbus.M_RDY ? mbus.M_ERR : 1'b1;

   // ---------------- state register ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= HDR;
      end else begin
         state <= next_state;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         HDR:   if (beat) next_state = AH;
         AH:    if (beat) next_state = AL;
         AL:    if (beat) next_state = wt_q ? DH : ISSUE;
         DH:    if (beat) next_state = DL;
         DL:    if (beat) next_state = ISSUE;
         ISSUE: if (issue_done) next_state = RESP;
         RESP:  if (rsp_done) next_state = HDR;
         default: next_state = HDR;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      BUSY = (state != HDR);
   end

   // Handshake outputs are registered from next_state so they line up with
   // the state they describe without a decode path to the pins.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ack_q     <= 1'b0;
         req_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         ack_q     <= (next_state == HDR) || (next_state == AH) ||
                      (next_state == AL)  || (next_state == DH) ||
                      (next_state == DL);
         req_q     <= (next_state == ISSUE);
         timeout_q <= (state == ISSUE) && !mbus.M_RDY && to_hit;
      end
   end

   // ---------------- request capture ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wt_q   <= 1'b0;
         be_q   <= '0;
         addr_q <= '0;
         wdt_q  <= '0;
      end else if (beat) begin
         case (state)
            HDR: begin
               wt_q  <= link.Ext_TRANS_DATA[HDR_WT];
               be_q  <= link.Ext_TRANS_DATA[HDR_BE_HI:HDR_BE_LO];
               // Reads carry no data; clear it so stale write data never
               // appears on M_WDT.
               wdt_q <= '0;
            end
            AH:      addr_q[31:16] <= link.Ext_TRANS_DATA;
            AL:      addr_q[15:0]  <= link.Ext_TRANS_DATA;
            DH:      wdt_q[31:16]  <= link.Ext_TRANS_DATA;
            DL:      wdt_q[15:0]   <= link.Ext_TRANS_DATA;
            default: ;
         endcase
      end
   end

   // ---------------- timeout counter ----------------
   // Held at zero outside ISSUE, so it starts from zero on every entry.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         to_cnt <= '0;
      end else if (state == ISSUE) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   // ---------------- response stream ----------------
   ext_resp_serializer u_resp (
      .clk        (CLK),
      .rst        (RST),
      .start      (issue_done),
      .is_read    (!wt_q),
      .word       (rsp_word),
      .err        (rsp_err),
      .resp_ack   (link.Ext_RESP_ACK),
      .resp_valid (link.Ext_RESP_VALID),
      .resp_err   (link.Ext_RESP_RESP),
      .resp_data  (link.Ext_RESP_DATA),
      .done       (rsp_done)
   );

   assign link.Ext_TRANS_ACK = ack_q;
   assign mbus.M_REQ         = req_q;
   assign mbus.M_WT          = wt_q;
   assign mbus.M_BE          = be_q;
   assign mbus.M_ADDR        = addr_q;
   assign mbus.M_WDT         = wdt_q;
   assign TIMEOUT            = timeout_q;

endmodule

// File: tb/tb_ext_intf_receiver.sv
// ----------------------------------------------------------------------------
// tb_ext_intf_receiver
// Directed bench for ext_intf_receiver (TIMEOUT_CYC = 8). Inputs change and
// outputs are sampled on the falling edge of CLK.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ext_intf_receiver;

   logic CLK;
   logic RST;
   logic busy;
   logic timeout;

   int checks = 0;
   int errors = 0;

   ext_link_if link ();
   ext_mbus_if mbus ();

   ext_intf_receiver #(
      .TIMEOUT_CYC (8),
      .TO_W        (3)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .link    (link.slave),
      .mbus    (mbus.master),
      .BUSY    (busy),
      .TIMEOUT (timeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one request beat and wait (bounded) until it is taken.
   task automatic send_beat(input logic [15:0] d);
      logic taken;
      taken = 1'b0;
      link.Ext_TRANS_VALID = 1'b1;
      link.Ext_TRANS_DATA  = d;
      for (int i = 0; i < 40; i++) begin
         if (link.Ext_TRANS_ACK === 1'b1) begin
            @(posedge CLK);
            @(negedge CLK);
            taken = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      check("beat_taken", {31'd0, taken}, 32'd1);
      link.Ext_TRANS_VALID = 1'b0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20; i++) begin
         if (mbus.M_REQ === 1'b1) break;
         @(negedge CLK);
      end
      check("req_up", {31'd0, mbus.M_REQ}, 32'd1);
   endtask

   // Keep the request pending for extra cycles, then complete it.
   task automatic complete_local(input int hold, input logic err, input logic [31:0] rdt);
      for (int i = 0; i < hold; i++) @(negedge CLK);
      check("req_held", {31'd0, mbus.M_REQ}, 32'd1);
      mbus.M_RDY = 1'b1;
      mbus.M_ERR = err;
      mbus.M_RDT = rdt;
      @(negedge CLK);
      mbus.M_RDY = 1'b0;
      mbus.M_ERR = 1'b0;
      mbus.M_RDT = 32'h0;
      check("req_drop", {31'd0, mbus.M_REQ}, 32'd0);
   endtask

   // Wait for a response beat, check it, hold ACK low for 'stall' cycles
   // checking the beat stays put, then accept it.
   task automatic recv_beat(input string tag, input logic [7:0] exp_d, input logic exp_e, input int stall);
      for (int i = 0; i < 40; i++) begin
         if (link.Ext_RESP_VALID === 1'b1) break;
         @(negedge CLK);
      end
      check({tag, "_beat"}, {22'd0, link.Ext_RESP_VALID, link.Ext_RESP_RESP, link.Ext_RESP_DATA},
            {22'd0, 1'b1, exp_e, exp_d});
      for (int s = 0; s < stall; s++) begin
         @(negedge CLK);
         check({tag, "_hold"}, {21'd0, busy, link.Ext_RESP_VALID, link.Ext_RESP_RESP, link.Ext_RESP_DATA},
               {21'd0, 1'b1, 1'b1, exp_e, exp_d});
      end
      link.Ext_RESP_ACK = 1'b1;
      @(negedge CLK);
      link.Ext_RESP_ACK = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check(tag, {29'd0, link.Ext_RESP_VALID, busy, link.Ext_TRANS_ACK}, {29'd0, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {24'd0, link.Ext_TRANS_ACK, link.Ext_RESP_VALID, link.Ext_RESP_RESP,
                            mbus.M_REQ, mbus.M_WT, busy, timeout, 1'b0},
            32'd0);
      check({tag, "_rdata"}, {20'd0, mbus.M_BE, link.Ext_RESP_DATA}, 32'd0);
      check({tag, "_addr"}, mbus.M_ADDR, 32'd0);
      check({tag, "_wdt"}, mbus.M_WDT, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int req_cycles;
      int to_cycles;

      RST = 1'b1;
      link.Ext_TRANS_VALID = 1'b0;
      link.Ext_TRANS_DATA  = 16'h0;
      link.Ext_RESP_ACK    = 1'b0;
      mbus.M_RDY = 1'b0;
      mbus.M_ERR = 1'b0;
      mbus.M_RDT = 32'h0;

      // ---- reset values, first ACK one cycle after release ----
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      check("ack_before_edge", {31'd0, link.Ext_TRANS_ACK}, 32'd0);
      @(negedge CLK);
      check_idle("ack_after_reset");

      // ---- write, no stall ----
      send_beat(16'h8800);
      send_beat(16'h1234);
      send_beat(16'h5678);
      send_beat(16'hDEAD);
      send_beat(16'hBEEF);
      wait_req();
      check("wr_wt_be", {27'd0, mbus.M_WT, mbus.M_BE}, {27'd0, 1'b1, 4'h1});
      check("wr_addr", mbus.M_ADDR, 32'h12345678);
      check("wr_wdt", mbus.M_WDT, 32'hDEADBEEF);
      check("wr_busy_noack", {30'd0, busy, link.Ext_TRANS_ACK}, {30'd0, 1'b1, 1'b0});
      complete_local(3, 1'b0, 32'h0);
      recv_beat("wr_rsp", 8'h00, 1'b0, 0);
      check_idle("wr_done");

      // ---- read, no stall ----
      send_beat(16'h7800);
      send_beat(16'h0000);
      send_beat(16'h0040);
      wait_req();
      check("rd_wt_be", {27'd0, mbus.M_WT, mbus.M_BE}, {27'd0, 1'b0, 4'hF});
      check("rd_addr", mbus.M_ADDR, 32'h00000040);
      complete_local(0, 1'b0, 32'hCAFEF00D);
      recv_beat("rd_b0", 8'hCA, 1'b0, 0);
      recv_beat("rd_b1", 8'hFE, 1'b0, 0);
      recv_beat("rd_b2", 8'hF0, 1'b0, 0);
      recv_beat("rd_b3", 8'h0D, 1'b0, 0);
      check_idle("rd_done");

      // ---- read with response backpressure ----
      send_beat(16'h7800);
      send_beat(16'h0000);
      send_beat(16'h0040);
      wait_req();
      complete_local(1, 1'b0, 32'hCAFEF00D);
      recv_beat("bp_b0", 8'hCA, 1'b0, 5);
      recv_beat("bp_b1", 8'hFE, 1'b0, 5);
      recv_beat("bp_b2", 8'hF0, 1'b0, 5);
      recv_beat("bp_b3", 8'h0D, 1'b0, 5);
      check_idle("bp_done");

      // ---- timeout: M_RDY never arrives ----
      send_beat(16'h7800);
      send_beat(16'hAAAA);
      send_beat(16'h5554);
      wait_req();
      req_cycles = 0;
      to_cycles  = 0;
      for (int i = 0; i < 20; i++) begin
         if (mbus.M_REQ === 1'b1) req_cycles++;
         if (timeout === 1'b1) to_cycles++;
         @(negedge CLK);
      end
      check("to_req_cycles", 32'(req_cycles), 32'd8);
      check("to_pulse_cycles", 32'(to_cycles), 32'd1);
      recv_beat("to_b0", 8'h00, 1'b1, 0);
      recv_beat("to_b1", 8'h00, 1'b1, 0);
      recv_beat("to_b2", 8'h00, 1'b1, 0);
      recv_beat("to_b3", 8'h00, 1'b1, 0);
      check_idle("to_done");

      // ---- write with local error; next header held off meanwhile ----
      send_beat(16'h8800);
      send_beat(16'h0000);
      send_beat(16'h1000);
      send_beat(16'h0000);
      send_beat(16'h00FF);
      wait_req();
      link.Ext_TRANS_VALID = 1'b1;
      link.Ext_TRANS_DATA  = 16'h7800;
      @(negedge CLK);
      check("issue_noack", {31'd0, link.Ext_TRANS_ACK}, 32'd0);
      complete_local(0, 1'b1, 32'h0);
      check("resp_noack", {31'd0, link.Ext_TRANS_ACK}, 32'd0);
      recv_beat("err_rsp", 8'h00, 1'b1, 0);
      check("hdr_ack_back", {30'd0, link.Ext_TRANS_ACK, link.Ext_RESP_VALID}, {30'd0, 1'b1, 1'b0});
      send_beat(16'h7800);
      send_beat(16'h0000);
      send_beat(16'h0080);
      wait_req();
      check("pend_wt_be", {27'd0, mbus.M_WT, mbus.M_BE}, {27'd0, 1'b0, 4'hF});
      check("pend_addr", mbus.M_ADDR, 32'h00000080);
      complete_local(0, 1'b0, 32'h11223344);
      recv_beat("pend_b0", 8'h11, 1'b0, 0);
      recv_beat("pend_b1", 8'h22, 1'b0, 0);
      recv_beat("pend_b2", 8'h33, 1'b0, 0);
      recv_beat("pend_b3", 8'h44, 1'b0, 0);
      check_idle("pend_done");

      // ---- reset in the middle of a write ----
      send_beat(16'h8800);
      send_beat(16'h9999);
      send_beat(16'h7777);
      RST = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge CLK);
      RST = 1'b0;
      req_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (mbus.M_REQ !== 1'b0) req_cycles++;
      end
      check("midrst_noreq", 32'(req_cycles), 32'd0);
      check_idle("midrst_idle");
      send_beat(16'hC000);
      send_beat(16'hA5A5);
      send_beat(16'h0F0F);
      send_beat(16'h0000);
      send_beat(16'h0001);
      wait_req();
      check("post_wt_be", {27'd0, mbus.M_WT, mbus.M_BE}, {27'd0, 1'b1, 4'h8});
      check("post_addr", mbus.M_ADDR, 32'hA5A50F0F);
      check("post_wdt", mbus.M_WDT, 32'h00000001);
      complete_local(2, 1'b0, 32'h0);
      recv_beat("post_rsp", 8'h00, 1'b0, 0);
      check_idle("post_done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
